// File: rtl/ula_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multi-cycle ULA.
// Op codes are the values driven by the ALU control decoder.
package ula_pkg;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_BNE_SUB = 5'd2;
  localparam logic [4:0] OP_SLT     = 5'd3;
  localparam logic [4:0] OP_SLTU    = 5'd4;
  localparam logic [4:0] OP_AND     = 5'd5;
  localparam logic [4:0] OP_OR      = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_LUI     = 5'd8;
  localparam logic [4:0] OP_SLL     = 5'd9;
  localparam logic [4:0] OP_SRL     = 5'd10;
  localparam logic [4:0] OP_SRA     = 5'd11;
  localparam logic [4:0] OP_NOR     = 5'd15;
  localparam logic [4:0] OP_MULT    = 5'd16;
  localparam logic [4:0] OP_MULTU   = 5'd17;
  localparam logic [4:0] OP_DIV     = 5'd18;
  localparam logic [4:0] OP_DIVU    = 5'd19;
  localparam logic [4:0] OP_MFHI    = 5'd20;
  localparam logic [4:0] OP_MFLO    = 5'd21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ula_mc_if.sv
// Request/response bundle between the EX-stage control and the multi-cycle ULA.
// Requester drives in_valid/op/operands; the ULA returns handshake, result and HI/LO.
interface ula_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output in_valid, op, in1, in2,
    input  in_ready, out_valid, result, zero_flag, hi, lo, busy
  );

  modport slave (
    input  in_valid, op, in1, in2,
    output in_ready, out_valid, result, zero_flag, hi, lo, busy
  );
endinterface

// File: rtl/ula_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, one bit per cycle.
// Runs WIDTH iterations after start_i; last_o flags the final one, with hi_o/lo_o valid alongside it.
module ula_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic             active_q;
  logic [SHW-1:0]   cnt_q;
  logic             div_q;
  logic             negq_q;
  logic             negr_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] sh_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   acc_it;
  logic [WIDTH-1:0] sh_it;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo, rem;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
  assign last_o = active_q && (cnt_q == SHW'(WIDTH-1));

  // Mul: acc:sh is the partial product, sh starts as the multiplier. Div: acc is the remainder, sh shifts dividend out / quotient in.
  always_comb begin
    sum     = acc_q + {1'b0, m_q};
    shifted = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, m_q};
    acc_it  = acc_q;
    sh_it   = sh_q;
    if (div_q) begin
      if (!diff[WIDTH+1]) begin
        acc_it = diff[WIDTH:0];
        sh_it  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_it = shifted;
        sh_it  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else if (sh_q[0]) begin
      {acc_it, sh_it} = {sum, sh_q} >> 1;
    end else begin
      {acc_it, sh_it} = {acc_q, sh_q} >> 1;
    end
  end

  always_comb begin
    prod   = {acc_it[WIDTH-1:0], sh_it};
    prod_s = negq_q ? -prod : prod;
    quo    = negq_q ? -sh_it : sh_it;
    rem    = negr_q ? -acc_it[WIDTH-1:0] : acc_it[WIDTH-1:0];
    hi_o   = div_q ? rem : prod_s[2*WIDTH-1:WIDTH];
    lo_o   = div_q ? quo : prod_s[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      div_q    <= div_i;
      negq_q   <= a_neg ^ b_neg;
      negr_q   <= div_i & a_neg;
      m_q      <= div_i ? b_mag : a_mag;
      sh_q     <= div_i ? a_mag : b_mag;
      acc_q    <= '0;
    end else if (active_q) begin
      acc_q <= acc_it;
      sh_q  <= sh_it;
      cnt_q <= cnt_q + SHW'(1);
      if (last_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ULA: single-cycle ops answer 1 cycle after accept, MULT/DIV after WIDTH+1.
// in_ready only in IDLE; requests seen in CALC or DONE are dropped, not queued.
module ula_mc
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  ula_mc_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             div_zero, div_ovf;
  logic             eng_start, eng_last;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign div_zero  = is_div(bus.op) && (bus.in2 == '0);
  assign div_ovf   = (bus.op == OP_DIV) && (bus.in1 == MIN_VAL) && (bus.in2 == '1);
  assign eng_start = accept && is_muldiv(bus.op) && !div_zero && !div_ovf;
  assign shamt     = bus.in1[SHW-1:0];

  ula_muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clock    (clock),
    .reset_n  (reset_n),
    .start_i  (eng_start),
    .div_i    (is_div(bus.op)),
    .signed_i ((bus.op == OP_MULT) || (bus.op == OP_DIV)),
    .a_i      (bus.in1),
    .b_i      (bus.in2),
    .last_o   (eng_last),
    .hi_o     (eng_hi),
    .lo_o     (eng_lo)
  );

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:             alu_res = bus.in1 + bus.in2;
      OP_SUB, OP_BNE_SUB: alu_res = bus.in1 - bus.in2;
      OP_SLT:             alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
      OP_SLTU:            alu_res = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
      OP_AND:             alu_res = bus.in1 & bus.in2;
      OP_OR:              alu_res = bus.in1 | bus.in2;
      OP_XOR:             alu_res = bus.in1 ^ bus.in2;
      OP_NOR:             alu_res = ~(bus.in1 | bus.in2);
      OP_LUI:             alu_res = bus.in2 << (WIDTH/2);
      OP_SLL:             alu_res = bus.in2 << shamt;
      OP_SRL:             alu_res = bus.in2 >> shamt;
      OP_SRA:             alu_res = $signed(bus.in2) >>> shamt;
      OP_MFHI:            alu_res = hi_q;
      OP_MFLO:            alu_res = lo_q;
      default:            alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = eng_start ? CALC : DONE;
      CALC:    if (eng_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q == CALC);
    bus.out_valid = (state_q == DONE);
  end

  // Divide-by-zero and signed overflow are resolved at accept and bypass the iterative engine.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept && !eng_start) begin
      if (div_zero) begin
        lo_d = '1;
        hi_d = bus.in1;
      end else if (div_ovf) begin
        lo_d = MIN_VAL;
        hi_d = '0;
      end
      result_d = (div_zero || div_ovf) ? lo_d : alu_res;
      zero_d   = (result_d == '0) ^ (bus.op == OP_BNE_SUB);
    end else if ((state_q == CALC) && eng_last) begin
      hi_d     = eng_hi;
      lo_d     = eng_lo;
      result_d = eng_lo;
      zero_d   = (eng_lo == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.zero_flag = zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_ula_mc.sv
// Scoreboard bench for ula_mc: expected results are queued at issue and popped on out_valid.
module tb_ula_mc;
  import ula_pkg::*;

  localparam int W = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  ula_mc_if #(.WIDTH(W)) bus ();

  ula_mc #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } tc_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit rdy_seen);
    int k = 0;
    @(negedge clock);
    while (!bus.in_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.in1      = a;
    bus.in2      = b;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in1      = $urandom();
    bus.in2      = $urandom();
    bus.op       = 5'($urandom_range(0, 31));
    lat      = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(negedge clock);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset in_ready got %b exp 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL reset busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.zero_flag !== 1'b0) begin n_err++; $display("FAIL reset zero_flag got %b exp 0", bus.zero_flag); end
    n_cmp++; if (bus.result !== '0)      begin n_err++; $display("FAIL reset result got %h exp 0", bus.result); end
    n_cmp++; if (bus.hi !== '0 || bus.lo !== '0) begin n_err++; $display("FAIL reset hi/lo got %h/%h exp 0/0", bus.hi, bus.lo); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    tc_t  t[16];
    exp_t e;
    int   lat;
    bit   rs;
    t[0]  = '{OP_ADD,     32'd7,        32'hFFFFFFF9, 32'h0,        1'b1, 0, 0, 1};
    t[1]  = '{OP_BNE_SUB, 32'd5,        32'd5,        32'h0,        1'b0, 0, 0, 1};
    t[2]  = '{OP_BNE_SUB, 32'd5,        32'd3,        32'h2,        1'b1, 0, 0, 1};
    t[3]  = '{OP_SUB,     32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 0, 0, 1};
    t[4]  = '{OP_SLT,     32'hFFFFFFFF, 32'd1,        32'h1,        1'b0, 0, 0, 1};
    t[5]  = '{OP_SLTU,    32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 0, 0, 1};
    t[6]  = '{OP_AND,     32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 0, 0, 1};
    t[7]  = '{OP_OR,      32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 0, 0, 1};
    t[8]  = '{OP_XOR,     32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 0, 0, 1};
    t[9]  = '{OP_NOR,     32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 0, 0, 1};
    t[10] = '{OP_LUI,     32'h0,        32'h00001234, 32'h12340000, 1'b0, 0, 0, 1};
    t[11] = '{OP_SLL,     32'd4,        32'd1,        32'h00000010, 1'b0, 0, 0, 1};
    t[12] = '{OP_SRL,     32'd4,        32'h80000000, 32'h08000000, 1'b0, 0, 0, 1};
    t[13] = '{OP_SRA,     32'd4,        32'h80000000, 32'hF8000000, 1'b0, 0, 0, 1};
    t[14] = '{5'd12,      32'd5,        32'd6,        32'h0,        1'b1, 0, 0, 1};
    t[15] = '{OP_SRA,     32'd36,       32'h40000000, 32'h04000000, 1'b0, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      sb.push_back('{res: t[i].res, z: t[i].z, hi: '0, lo: '0, lat: t[i].lat});
      run_op(t[i].op, t[i].a, t[i].b, lat, rs);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL alu[%0d] latency got %0d exp %0d", i, lat, e.lat); end
      n_cmp++; if (bus.result !== e.res) begin n_err++; $display("FAIL alu[%0d] result got %h exp %h", i, bus.result, e.res); end
      n_cmp++; if (bus.zero_flag !== e.z) begin n_err++; $display("FAIL alu[%0d] zero_flag got %b exp %b", i, bus.zero_flag, e.z); end
    end
  endtask

  task automatic test_muldiv();
    tc_t  t[13];
    exp_t e;
    int   lat;
    bit   rs;
    t[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 33};
    t[1]  = '{OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1};
    t[2]  = '{OP_MFLO,  32'h0,        32'h0,        32'hFFFFFFFA, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1};
    t[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33};
    t[4]  = '{OP_MULT,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFDD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFDD, 33};
    t[5]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h0,        1'b1, 32'h00000001, 32'h0,        33};
    t[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    t[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'h00000001, 32'hFFFFFFFD, 33};
    t[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 32'd2,        32'd14,       33};
    t[9]  = '{OP_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 32'd9,        32'hFFFFFFFF, 1};
    t[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h0,        32'h80000000, 1};
    t[11] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
    t[12] = '{OP_DIV,   32'd0,        32'd5,        32'h0,        1'b1, 32'h0,        32'h0,        33};
    for (int i = 0; i < 13; i++) begin
      sb.push_back('{res: t[i].res, z: t[i].z, hi: t[i].hi, lo: t[i].lo, lat: t[i].lat});
      run_op(t[i].op, t[i].a, t[i].b, lat, rs);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL md[%0d] latency got %0d exp %0d", i, lat, e.lat); end
      n_cmp++; if (bus.result !== e.res) begin n_err++; $display("FAIL md[%0d] result got %h exp %h", i, bus.result, e.res); end
      n_cmp++; if (bus.zero_flag !== e.z) begin n_err++; $display("FAIL md[%0d] zero_flag got %b exp %b", i, bus.zero_flag, e.z); end
      n_cmp++; if (bus.hi !== e.hi) begin n_err++; $display("FAIL md[%0d] hi got %h exp %h", i, bus.hi, e.hi); end
      n_cmp++; if (bus.lo !== e.lo) begin n_err++; $display("FAIL md[%0d] lo got %h exp %h", i, bus.lo, e.lo); end
      n_cmp++; if (rs !== 1'b0) begin n_err++; $display("FAIL md[%0d] in_ready_before_done got %b exp 0", i, rs); end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   lat = 1;
    int   extra = 0;
    bit   busy_low = 1'b0;
    sb.push_back('{res: 32'd15, z: 1'b0, hi: 32'h0, lo: 32'd15, lat: 33});
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op       = OP_MULTU;
    bus.in1      = 32'd3;
    bus.in2      = 32'd5;
    @(negedge clock);
    bus.op  = OP_ADD;
    bus.in1 = 32'd100;
    bus.in2 = 32'd200;
    while (!bus.out_valid && lat < 100) begin
      if (!bus.busy) busy_low = 1'b1;
      @(negedge clock);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL busy_ignore latency got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (bus.result !== e.res) begin n_err++; $display("FAIL busy_ignore result got %h exp %h", bus.result, e.res); end
    n_cmp++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin n_err++; $display("FAIL busy_ignore hi/lo got %h/%h exp %h/%h", bus.hi, bus.lo, e.hi, e.lo); end
    n_cmp++; if (busy_low !== 1'b0) begin n_err++; $display("FAIL busy_ignore busy_dropped got %b exp 0", busy_low); end
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid) extra++;
      @(negedge clock);
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL busy_ignore extra_out_valid got %0d exp 0", extra); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL busy_ignore in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_abort();
    exp_t e;
    int   lat;
    int   seen = 0;
    bit   rs;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op       = OP_MULTU;
    bus.in1      = 32'h0000FFFF;
    bus.in2      = 32'h0000FFFF;
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clock);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort busy_before got %b exp 1", bus.busy); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL abort in_ready got %b exp 1", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.hi !== '0 || bus.lo !== '0) begin n_err++; $display("FAIL abort hi/lo got %h/%h exp 0/0", bus.hi, bus.lo); end
    n_cmp++; if (bus.result !== '0) begin n_err++; $display("FAIL abort result got %h exp 0", bus.result); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      @(negedge clock);
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort stray_out_valid got %0d exp 0", seen); end
    n_cmp++; if (bus.hi !== '0 || bus.lo !== '0) begin n_err++; $display("FAIL abort hi/lo_after got %h/%h exp 0/0", bus.hi, bus.lo); end
    sb.push_back('{res: 32'd5, z: 1'b0, hi: 32'h0, lo: 32'h0, lat: 1});
    run_op(OP_ADD, 32'd2, 32'd3, lat, rs);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL abort add latency got %0d exp %0d", lat, e.lat); end
    n_cmp++; if (bus.result !== e.res) begin n_err++; $display("FAIL abort add result got %h exp %h", bus.result, e.res); end
    n_cmp++; if (bus.zero_flag !== e.z) begin n_err++; $display("FAIL abort add zero_flag got %b exp %b", bus.zero_flag, e.z); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.in1      = '0;
    bus.in2      = '0;
    test_reset();
    test_alu();
    test_muldiv();
    test_busy_ignore();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ula_mc.md
Name: ula_mc

Overview:
Parametrised multi-cycle successor of the single-cycle ULA. It executes every existing ULA operation with one registered cycle of latency. It adds iterative signed/unsigned multiply and divide into internal HI/LO registers, plus MFHI/MFLO reads. It sits in the datapath EX stage behind the ALU control decoder, and the control FSM stalls on the in_ready/out_valid handshake.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 8
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request; accepted when in_valid & in_ready
in_ready  out  1  high only in IDLE
op  in  5  operation code (ula_pkg)
in1  in  WIDTH  operand A
in2  in  WIDTH  operand B
out_valid  out  1  one-cycle pulse, result/zero_flag valid
result  out  WIDTH  registered result; holds until next out_valid
zero_flag  out  1  registered with result
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)
busy  out  1  high in CALC

Behaviour:
- Reset (async assert, sync release): state=IDLE; result, hi, lo=0; zero_flag=0; out_valid=0; in_ready=1; busy=0.
- States: IDLE -> (accept, single-cycle op) -> DONE; IDLE -> (accept, mul/div op) -> CALC; CALC -> DONE when iteration counter reaches WIDTH-1; DONE -> IDLE unconditionally. out_valid=1 only in DONE.
- Single-cycle op latency: accept at edge N, out_valid high in cycle N+1. Next accept is possible at N+2.
- Operand rules:
  - ADD/SUB/BNE-SUB are modulo 2^WIDTH.
  - SLT is signed; SLTU is unsigned.
  - AND/OR/XOR/NOR are bitwise.
  - LUI = in2 << WIDTH/2.
  - SLL/SRL/SRA all shift in2 by in1[SHW-1:0]. SRA is arithmetic on in2.
  - MFHI/MFLO return hi/lo.
  - Undefined op: result=0, out_valid still pulses.
- zero_flag = (result==0), inverted when op==BNE_SUB. Computed from the new result and latched in the same edge.
- MULT/MULTU: shift-add over the magnitudes, WIDTH iterations. Signed case uses the sign-corrected 2*WIDTH product. {hi,lo}=product. result=lo.
- DIV/DIVU: restoring division, WIDTH iterations. lo=quotient, hi=remainder. Remainder takes the sign of the dividend (truncating). result=lo.
- Mul/div latency: accept at N, out_valid at N+WIDTH+1.
- hi/lo update only at CALC->DONE. Intermediate values live in working registers.
- Divide by zero is detected at accept and skips CALC (latency 1): lo=all ones, hi=in1.
- Signed overflow (in1=MIN, in2=-1) is detected at accept and skips CALC: lo=MIN, hi=0.
- in_valid while busy or in DONE is ignored (not queued). Operands and op are captured at accept, so later input changes are irrelevant.
- reset_n low mid-CALC aborts the operation. hi/lo return to 0. No out_valid is produced.
- MFHI issued immediately after a mul/div (in the cycle after DONE) returns the updated hi.

Decomposition:
- ula_pkg holds:
  - op constants: ADD=0, SUB=1, BNE_SUB=2, SLT=3, SLTU=4, AND=5, OR=6, XOR=7, LUI=8, SLL=9, SRL=10, SRA=11, NOR=15, MULT=16, MULTU=17, DIV=18, DIVU=19, MFHI=20, MFLO=21.
  - the state enum IDLE/CALC/DONE.
  - an is_muldiv() helper function.
- Sub-module ula_muldiv_iter contains the shift-add/restoring engine with start/done, counter and working registers.
- ula_mc contains the handshake FSM, the single-cycle ALU case, and the hi/lo/result registers.

Test Plan:
- Reset with reset_n=0 mid-cycle -> all outputs 0, in_ready=1 immediately, without a clock edge.
- ADD 7+(-7) -> next cycle out_valid=1, result=0, zero_flag=1. BNE_SUB 5,5 -> result=0, zero_flag=0.
- SRA in1=4, in2=0x80000000 -> result=0xF8000000. LUI in2=0x1234 -> 0x12340000.
- MULT 0xFFFFFFFE * 3 -> out_valid exactly 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFA, in_ready=0 throughout CALC. Then MFHI -> 0xFFFFFFFF.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 9/0 -> latency 1, lo=0xFFFFFFFF, hi=9. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Start MULTU, pull reset_n low at cycle 10 -> no out_valid, hi=lo=0. A new ADD after release completes normally.
